// File: rtl/alu_sequencer.sv
// alu_sequencer: owns the shared combinational ALU for the microsequencer.
// One request in flight; operands are registered onto the ALU inputs, the
// ALU's per-op extra delay (plus DELAY_BIAS) is honoured, and result/flags are
// returned through a registered response channel.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid && ready are both 1. The producer holds valid and payload stable until
// the transfer. req_* are ignored while req_ready=0. rsp_* stay stable while
// rsp_valid=1 and rsp_ready=0.
module alu_sequencer #(
  parameter int unsigned DELAY_BIAS          = 0,     // 0..15 extra wait cycles on every op
  parameter bit          FLAGS_FROM_ALU_ONLY = 1'b1,
  parameter int unsigned OP_W                = 5,     // width of the ALU operation code
  parameter int unsigned FLAGS_W             = 8      // {2'b0, V, S, Z, AC, P, CY}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_W-1:0]    req_op,
  input  logic [15:0]        req_ta,
  input  logic [15:0]        req_tb,
  input  logic               req_wide,
  input  logic               req_flag_we,
  input  logic [FLAGS_W-1:0] flags_cur,
  output logic [OP_W-1:0]    alu_operation,
  output logic [15:0]        alu_ta,
  output logic [15:0]        alu_tb,
  output logic               alu_wide,
  output logic [FLAGS_W-1:0] alu_flags_in,
  input  logic [15:0]        alu_result,
  input  logic [9:0]         alu_delay,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_result,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               rsp_flag_we,
  output logic               busy,
  input  logic               flush,
  output logic [1:0]         dbg_state       // FSM state, for observation only
);

  localparam logic [OP_W-1:0] ALU_OP_ADD = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q,      state_d;
  logic [OP_W-1:0]    op_q,         op_d;
  logic [15:0]        ta_q,         ta_d;
  logic [15:0]        tb_q,         tb_d;
  logic               wide_q,       wide_d;
  logic               flag_we_q,    flag_we_d;      // pending flag_we of the op in flight
  logic [FLAGS_W-1:0] flags_hold_q, flags_hold_d;   // flags_cur as seen in EXEC
  logic [10:0]        cnt_q,        cnt_d;          // 11 bits: 1023+15 never wraps
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic [FLAGS_W-1:0] rsp_flags_q,  rsp_flags_d;
  logic               rsp_fwe_q,    rsp_fwe_d;

  logic               accept;
  logic [10:0]        n_wait;
  logic [FLAGS_W-1:0] exec_flags;

  // Ready when idle, or when the finished response is consumed this cycle
  // (back-to-back issue); a flush cycle never accepts.
  always_comb begin
    req_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready));
    accept    = req_valid && req_ready;
    n_wait    = {1'b0, alu_delay} + 11'(DELAY_BIAS);
    // ALU sees live core flags in EXEC so a dependent op picks up the flags
    // the core wrote on the previous response handshake; held afterwards.
    alu_flags_in = (state_q == S_EXEC) ? flags_cur : flags_hold_q;
    exec_flags   = (!FLAGS_FROM_ALU_ONLY && !flag_we_q) ? flags_cur : alu_flags;
  end

  // Next-state and datapath-load logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ta_d         = ta_q;
    tb_d         = tb_q;
    wide_d       = wide_q;
    flag_we_d    = flag_we_q;
    flags_hold_d = flags_hold_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_fwe_d    = rsp_fwe_q;

    if (accept) begin
      op_d      = req_op;
      ta_d      = req_ta;
      tb_d      = req_tb;
      wide_d    = req_wide;
      flag_we_d = req_flag_we;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        flags_hold_d = flags_cur;
        rsp_result_d = alu_result;
        rsp_flags_d  = exec_flags;
        rsp_fwe_d    = flag_we_q;
        if (n_wait == 11'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = n_wait;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 11'd1;
        if (cnt_q == 11'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = accept ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts the op; response data is deliberately left in place.
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= ALU_OP_ADD;
      ta_q         <= '0;
      tb_q         <= '0;
      wide_q       <= 1'b0;
      flag_we_q    <= 1'b0;
      flags_hold_q <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_fwe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ta_q         <= ta_d;
      tb_q         <= tb_d;
      wide_q       <= wide_d;
      flag_we_q    <= flag_we_d;
      flags_hold_q <= flags_hold_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_fwe_q    <= rsp_fwe_d;
    end
  end

  // Output mapping.
  always_comb begin
    alu_operation = op_q;
    alu_ta        = ta_q;
    alu_tb        = tb_q;
    alu_wide      = wide_q;
    rsp_valid     = (state_q == S_DONE);
    rsp_result    = rsp_result_q;
    rsp_flags     = rsp_flags_q;
    rsp_flag_we   = rsp_fwe_q;
    busy          = (state_q != S_IDLE);
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table-driven single-op vectors on a DUT with
// default parameters, hand-written back-to-back / backpressure / flush
// sequences, and a second DUT (DELAY_BIAS=2, FLAGS_FROM_ALU_ONLY=0) for the
// bias, flag-passthrough and mid-op reset cases. A small ALU model drives
// each DUT's ALU inputs.
module tb_alu_sequencer;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDC  = 5'd1;
  localparam logic [4:0] OP_XOR   = 5'd3;
  localparam logic [4:0] OP_ADJ4A = 5'd4;
  localparam logic [4:0] OP_ADJ4S = 5'd5;
  localparam int F_CY = 0;
  localparam int F_AC = 2;

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  fl;
    logic [9:0]  dly;
  } alu_out_t;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] ta;
    logic [15:0] tb;
    logic        wide;
    logic        fwe;
    logic [7:0]  fcur;
    logic [15:0] exp_res;
    logic [7:0]  exp_fl;
    int          lat;
  } vec_t;

  // ---------------- clock / reset / shared inputs ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wide, req_flag_we, rsp_ready, flush;
  logic [4:0]  req_op;
  logic [15:0] req_ta, req_tb;
  logic [7:0]  flags_cur;

  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic        req_ready, alu_wide, rsp_valid, rsp_flag_we, busy;
  logic [4:0]  alu_operation;
  logic [15:0] alu_ta, alu_tb, alu_result, rsp_result;
  logic [7:0]  alu_flags_in, alu_flags, rsp_flags;
  logic [9:0]  alu_delay;
  logic [1:0]  dbg_state;
  alu_out_t    ao;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ta(req_ta), .req_tb(req_tb), .req_wide(req_wide),
    .req_flag_we(req_flag_we), .flags_cur(flags_cur),
    .alu_operation(alu_operation), .alu_ta(alu_ta), .alu_tb(alu_tb),
    .alu_wide(alu_wide), .alu_flags_in(alu_flags_in), .alu_result(alu_result),
    .alu_delay(alu_delay), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_flag_we(rsp_flag_we), .busy(busy), .flush(flush), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (bias 2, flag passthrough) ----------------
  logic        req_ready_b, alu_wide_b, rsp_valid_b, rsp_flag_we_b, busy_b;
  logic [4:0]  alu_operation_b;
  logic [15:0] alu_ta_b, alu_tb_b, alu_result_b, rsp_result_b;
  logic [7:0]  alu_flags_in_b, alu_flags_b, rsp_flags_b;
  logic [9:0]  alu_delay_b;
  logic [1:0]  dbg_state_b;
  alu_out_t    ao_b;

  alu_sequencer #(.DELAY_BIAS(2), .FLAGS_FROM_ALU_ONLY(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_op(req_op), .req_ta(req_ta), .req_tb(req_tb), .req_wide(req_wide),
    .req_flag_we(req_flag_we), .flags_cur(flags_cur),
    .alu_operation(alu_operation_b), .alu_ta(alu_ta_b), .alu_tb(alu_tb_b),
    .alu_wide(alu_wide_b), .alu_flags_in(alu_flags_in_b), .alu_result(alu_result_b),
    .alu_delay(alu_delay_b), .alu_flags(alu_flags_b), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result_b), .rsp_flags(rsp_flags_b),
    .rsp_flag_we(rsp_flag_we_b), .busy(busy_b), .flush(flush), .dbg_state(dbg_state_b)
  );

  // ---------------- ALU model (external component) ----------------
  function automatic alu_out_t alu_model(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic wide,
                                         input logic [7:0] fin);
    alu_out_t    o;
    logic [16:0] s;
    logic [4:0]  n4;
    logic [7:0]  t;
    logic [15:0] r;
    logic        cin, cy, ac, v, sf, zf;
    o = '0; s = '0; n4 = '0; t = '0; r = '0; cy = 1'b0; ac = 1'b0; v = 1'b0;
    cin = (op == OP_ADDC) ? fin[F_CY] : 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        n4 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
        ac = n4[4];
        if (wide) begin
          s  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
          r  = s[15:0];
          cy = s[16];
          v  = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
          s  = {9'd0, a[7:0]} + {9'd0, b[7:0]} + {16'd0, cin};
          r  = {8'd0, s[7:0]};
          cy = s[8];
          v  = (a[7] == b[7]) && (r[7] != a[7]);
        end
      end
      OP_XOR: r = wide ? (a ^ b) : {8'd0, a[7:0] ^ b[7:0]};
      OP_ADJ4A, OP_ADJ4S: begin
        t  = a[7:0];
        cy = fin[F_CY];
        if (a[3:0] > 4'd9 || fin[F_AC]) begin
          t  = (op == OP_ADJ4A) ? t + 8'h06 : t - 8'h06;
          ac = 1'b1;
        end
        if (a[7:4] > 4'd9 || fin[F_CY]) begin
          t  = (op == OP_ADJ4A) ? t + 8'h60 : t - 8'h60;
          cy = 1'b1;
        end
        r     = {8'd0, t};
        o.dly = 10'd3;
      end
      default: r = '0;
    endcase
    sf   = wide ? r[15] : r[7];
    zf   = wide ? (r == 16'd0) : (r[7:0] == 8'd0);
    o.res = r;
    o.fl  = {2'b00, v, sf, zf, ac, ~^r[7:0], cy};
    return o;
  endfunction

  always_comb ao   = alu_model(alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in);
  always_comb ao_b = alu_model(alu_operation_b, alu_ta_b, alu_tb_b, alu_wide_b, alu_flags_in_b);
  assign alu_result   = ao.res;
  assign alu_flags    = ao.fl;
  assign alu_delay    = ao.dly;
  assign alu_result_b = ao_b.res;
  assign alu_flags_b  = ao_b.fl;
  assign alu_delay_b  = ao_b.dly;

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [15:0] ta, input logic [15:0] tb,
                           input logic wide, input logic fwe);
    req_op = op; req_ta = ta; req_tb = tb; req_wide = wide; req_flag_we = fwe;
    req_valid = 1'b1;
  endtask

  // Called at cycle 1 after the accept edge; returns the cycle rsp_valid rose.
  task automatic wait_rsp(input bit use_b, input string nm, output int cyc);
    cyc = 1;
    while (!(use_b ? rsp_valid_b : rsp_valid) && cyc < 1100) begin
      chk({nm, "_busy_wait"}, 32'(use_b ? busy_b : busy), 1);
      tick(); settle();
      cyc++;
    end
    if (cyc >= 1100) chk({nm, "_rsp_timeout"}, 32'(cyc), 0);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    settle();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    cyc;
    string nm;
    nm = $sformatf("vec%0d", idx);
    tick();
    drive_req(v.op, v.ta, v.tb, v.wide, v.fwe);
    flags_cur = v.fcur;
    rsp_ready = 1'b0;
    settle();
    chk({nm, "_req_ready"}, 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    settle();
    wait_rsp(1'b0, nm, cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'(v.lat));
    chk({nm, "_result"}, 32'(rsp_result), 32'(v.exp_res));
    chk({nm, "_flags"}, 32'(rsp_flags), 32'(v.exp_fl));
    chk({nm, "_flag_we"}, 32'(rsp_flag_we), 32'(v.fwe));
    rsp_ready = 1'b1;
    settle();
    chk({nm, "_req_ready_done"}, 32'(req_ready), 1);
    tick();
    rsp_ready = 1'b0;
    settle();
    chk({nm, "_idle_after"}, 32'(busy), 0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];
  int   cyc;

  initial begin
    vecs[0] = '{OP_ADD,   16'h7FFF, 16'h0001, 1'b1, 1'b1, 8'h00, 16'h8000, 8'h36, 2};
    vecs[1] = '{OP_ADJ4A, 16'h000F, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h0015, 8'h04, 5};
    vecs[2] = '{OP_ADD,   16'hFFFF, 16'h0001, 1'b1, 1'b1, 8'h00, 16'h0000, 8'h0F, 2};
    vecs[3] = '{OP_ADD,   16'h0080, 16'h0080, 1'b0, 1'b1, 8'h00, 16'h0000, 8'h2B, 2};
    vecs[4] = '{OP_ADDC,  16'h0001, 16'h0001, 1'b1, 1'b1, 8'h01, 16'h0003, 8'h02, 2};
    vecs[5] = '{OP_ADJ4S, 16'h002F, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h0029, 8'h04, 5};
    vecs[6] = '{OP_XOR,   16'h1234, 16'h00FF, 1'b1, 1'b0, 8'h3F, 16'h12CB, 8'h00, 2};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_ta = '0; req_tb = '0; req_wide = 1'b0; req_flag_we = 1'b0;
    flags_cur = '0;
    repeat (3) tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_flags", 32'(rsp_flags), 0);
    chk("rst_rsp_flag_we", 32'(rsp_flag_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_op", 32'(alu_operation), 32'(OP_ADD));
    chk("rst_alu_ta", 32'(alu_ta), 0);
    chk("rst_alu_tb", 32'(alu_tb), 0);
    chk("rst_alu_wide", 32'(alu_wide), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // Table-driven single ops
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Back-to-back: ADD FFFF+1 then ADDC 0+0 picks up CY written on handshake
    tick();
    drive_req(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    flags_cur = 8'h00; rsp_ready = 1'b1;
    settle();
    tick();                                            // cycle 1
    drive_req(OP_ADDC, 16'h0000, 16'h0000, 1'b1, 1'b1);
    settle();
    chk("b2b_exec_ready", 32'(req_ready), 0);
    chk("b2b_exec_state", 32'(dbg_state), 1);
    tick(); settle();                                  // cycle 2
    chk("b2b_rsp1_valid", 32'(rsp_valid), 1);
    chk("b2b_rsp1_result", 32'(rsp_result), 32'h0000);
    chk("b2b_rsp1_flags", 32'(rsp_flags), 32'h0F);
    chk("b2b_rsp1_req_ready", 32'(req_ready), 1);
    tick();                                            // cycle 3
    req_valid = 1'b0;
    flags_cur = 8'h0F;                                 // core writes back on handshake
    settle();
    chk("b2b_exec2_valid", 32'(rsp_valid), 0);
    chk("b2b_exec2_op", 32'(alu_operation), 32'(OP_ADDC));
    tick(); settle();                                  // cycle 4
    chk("b2b_rsp2_valid", 32'(rsp_valid), 1);
    chk("b2b_rsp2_result", 32'(rsp_result), 32'h0001);
    chk("b2b_rsp2_flags", 32'(rsp_flags), 32'h00);
    tick(); settle();                                  // cycle 5
    chk("b2b_idle", 32'(busy), 0);
    rsp_ready = 1'b0;
    flags_cur = 8'h00;

    // Backpressure: response held, pending request refused
    tick();
    drive_req(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b1);
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    wait_rsp(1'b0, "bp", cyc);
    chk("bp_latency", 32'(cyc), 2);
    drive_req(OP_XOR, 16'h00FF, 16'h00FF, 1'b0, 1'b1);
    settle();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("bp_hold%0d_result", k), 32'(rsp_result), 32'h8000);
      chk($sformatf("bp_hold%0d_flags", k), 32'(rsp_flags), 32'h36);
      chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 0);
      chk($sformatf("bp_hold%0d_alu_op", k), 32'(alu_operation), 32'(OP_ADD));
      tick(); settle();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(req_ready), 1);
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    settle();
    chk("bp_next_valid", 32'(rsp_valid), 0);
    chk("bp_next_op", 32'(alu_operation), 32'(OP_XOR));
    chk("bp_next_ta", 32'(alu_ta), 32'h00FF);
    wait_rsp(1'b0, "bp2", cyc);
    chk("bp2_latency", 32'(cyc), 2);
    chk("bp2_result", 32'(rsp_result), 32'h0000);
    chk("bp2_flags", 32'(rsp_flags), 32'h0A);
    consume();

    // Flush at cycle 2 of ADJ4S (n=3)
    tick();
    drive_req(OP_ADJ4S, 16'h002F, 16'h0000, 1'b0, 1'b1);
    settle();
    tick();                                            // cycle 1
    req_valid = 1'b0;
    settle();
    chk("fl_c1_busy", 32'(busy), 1);
    tick();                                            // cycle 2
    flush = 1'b1;
    drive_req(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b1);
    settle();
    chk("fl_c2_req_ready", 32'(req_ready), 0);
    chk("fl_c2_state", 32'(dbg_state), 2);
    tick();                                            // cycle 3
    flush = 1'b0;
    settle();
    chk("fl_c3_busy", 32'(busy), 0);
    chk("fl_c3_valid", 32'(rsp_valid), 0);
    chk("fl_c3_req_ready", 32'(req_ready), 1);
    chk("fl_c3_rsp_kept", 32'(rsp_result), 32'h0029);
    chk("fl_c3_alu_op", 32'(alu_operation), 32'(OP_ADJ4S));
    tick();                                            // accepted at cycle 3
    req_valid = 1'b0;
    settle();
    wait_rsp(1'b0, "fl_next", cyc);
    chk("fl_next_latency", 32'(cyc), 2);
    chk("fl_next_result", 32'(rsp_result), 32'h0002);
    chk("fl_next_flags", 32'(rsp_flags), 32'h00);
    consume();

    // DUT B: DELAY_BIAS=2, FLAGS_FROM_ALU_ONLY=0
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    settle();
    tick();
    drive_req(OP_XOR, 16'h00FF, 16'h00FF, 1'b0, 1'b1);
    settle();
    chk("b_xor_req_ready", 32'(req_ready_b), 1);
    tick();
    req_valid = 1'b0;
    settle();
    wait_rsp(1'b1, "b_xor", cyc);
    chk("b_xor_latency", 32'(cyc), 4);
    chk("b_xor_result", 32'(rsp_result_b), 32'h0000);
    chk("b_xor_flags", 32'(rsp_flags_b), 32'h0A);
    chk("b_xor_flag_we", 32'(rsp_flag_we_b), 1);
    consume();

    tick();
    drive_req(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b0);
    flags_cur = 8'h25;
    settle();
    tick();
    req_valid = 1'b0;
    settle();
    wait_rsp(1'b1, "b_pass", cyc);
    chk("b_pass_latency", 32'(cyc), 4);
    chk("b_pass_result", 32'(rsp_result_b), 32'h0002);
    chk("b_pass_flags", 32'(rsp_flags_b), 32'h25);
    chk("b_pass_flag_we", 32'(rsp_flag_we_b), 0);
    consume();

    // Reset at cycle 1 of an op
    tick();
    drive_req(OP_XOR, 16'h1234, 16'h00FF, 1'b1, 1'b1);
    settle();
    tick();                                            // cycle 1
    req_valid = 1'b0;
    reset = 1'b1;
    settle();
    chk("b_rst_pre_busy", 32'(busy_b), 1);
    tick();
    reset = 1'b0;
    settle();
    chk("b_rst_req_ready", 32'(req_ready_b), 1);
    chk("b_rst_rsp_valid", 32'(rsp_valid_b), 0);
    chk("b_rst_rsp_result", 32'(rsp_result_b), 0);
    chk("b_rst_rsp_flags", 32'(rsp_flags_b), 0);
    chk("b_rst_rsp_flag_we", 32'(rsp_flag_we_b), 0);
    chk("b_rst_busy", 32'(busy_b), 0);
    chk("b_rst_alu_op", 32'(alu_operation_b), 32'(OP_ADD));
    chk("b_rst_alu_ta", 32'(alu_ta_b), 0);
    chk("b_rst_alu_tb", 32'(alu_tb_b), 0);
    chk("b_rst_alu_wide", 32'(alu_wide_b), 0);
    chk("b_rst_state", 32'(dbg_state_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
